ucore_sequencer: RTL

Parametrised microprogram sequencer: the generic next-state engine for microcoded cores. It replaces per-program hardwired state encodings with a registered micro-program counter (`upc`) driving an external asynchronous microcode ROM, and adds conditional branching, wait-on-condition, a call/return stack, halt and error reporting. It sits between the microcode ROM and the core datapath, which decodes the remaining ROM fields itself.

---
 rtl/ucore_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ucore_sequencer.sv
// Microprogram sequencer: registered micro-PC driving an async microcode ROM,
// with conditional branch, wait-on-condition, call/return stack, halt and sticky errors.
module ucore_sequencer #(
  parameter  int ADDR_W      = 12,
  parameter  int COND_W      = 8,
  parameter  int STACK_DEPTH = 4,
  parameter  int RESET_ADDR  = 0,
  localparam int SEL_W       = $clog2(COND_W),
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        uop,
  input  logic [ADDR_W-1:0] utarget,
  input  logic [SEL_W-1:0]  ucond_sel,
  input  logic              ucond_pol,
  input  logic [COND_W-1:0] cond,
  output logic [ADDR_W-1:0] upc,
  output logic [SP_W-1:0]   sp,
  output logic              halted,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_illegal
);

  // Storage rounded up to a power of two so sp indexes it without width games;
  // entries at or above STACK_DEPTH are never written.
  localparam int STK_N = 1 << SP_W;

  typedef enum logic {S_RUN, S_HALT} state_t;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_WAIT   = 3'd5,
    OP_HALT   = 3'd6,
    OP_ILL    = 3'd7
  } op_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] upc_n, inc, top;
  logic [SP_W-1:0]   sp_n;
  logic              eo_n, eu_n, ei_n;
  logic              push;
  logic              sel_ok, t;
  logic [ADDR_W-1:0] stack_mem [STK_N];

  always_comb begin
    sel_ok = 32'(ucond_sel) < COND_W;
    t      = sel_ok & (cond[ucond_sel] ^ ucond_pol);
    inc    = upc + ADDR_W'(1);
    top    = stack_mem[sp - SP_W'(1)];
  end

  always_comb begin
    state_n = state;
    upc_n   = upc;
    sp_n    = sp;
    push    = 1'b0;
    eo_n    = err_overflow;
    eu_n    = err_underflow;
    ei_n    = err_illegal;
    if (state == S_RUN && !stall) begin
      unique case (op_t'(uop))
        OP_NEXT:   upc_n = inc;
        OP_JUMP:   upc_n = utarget;
        OP_BRANCH: upc_n = t ? utarget : inc;
        OP_CALL: begin
          if (sp < SP_W'(STACK_DEPTH)) begin
            push  = 1'b1;
            sp_n  = sp + SP_W'(1);
            upc_n = utarget;
          end else begin
            eo_n    = 1'b1;
            state_n = S_HALT;
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            upc_n = top;
            sp_n  = sp - SP_W'(1);
          end else begin
            eu_n    = 1'b1;
            state_n = S_HALT;
          end
        end
        OP_WAIT:   upc_n = t ? inc : upc;
        OP_HALT:   state_n = S_HALT;
        OP_ILL: begin
          ei_n    = 1'b1;
          state_n = S_HALT;
        end
        default:   upc_n = upc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      upc           <= ADDR_W'(RESET_ADDR);
      sp            <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      state         <= state_n;
      upc           <= upc_n;
      sp            <= sp_n;
      err_overflow  <= eo_n;
      err_underflow <= eu_n;
      err_illegal   <= ei_n;
    end
  end

  // Stack contents are don't-care after reset; a reset cycle simply drops the push.
  always_ff @(posedge clk) begin
    if (!reset && push) stack_mem[sp] <= inc;
  end

  assign halted = (state == S_HALT);

endmodule
